reg_status_table: RTL and testbench
===================================

// Module: reg_status_table
// PURPOSE
//  Parametrised successor of the register file + status table for the Tomasulo core.
//  Holds architectural values and, per register, the FU tag that will produce it (READY = valid).
//  N read ports feed issue. Issue renames a destination. CDB broadcast retires matching tags in all regs.
//  Flush clears all renames. Sits between decode/issue and the reservation stations.
// PARAMETERS
//  WORD_SIZE   32  data width
//  REG_INDEX   5   register index width; REG_FILE_SIZE = 1<<REG_INDEX
//  FU_INDEX    3   FU tag width
//  NUM_READ    3   number of read ports
//  READY       0   tag value meaning "no pending producer"
// PORTS
//  clk        in   1                   clock, all state updates on posedge
//  reset_n    in   1                   asynchronous, active-low reset
//  rd_num     in   NUM_READ*REG_INDEX  read indices; port k = bits [k*REG_INDEX +: REG_INDEX]
//  rd_value   out  NUM_READ*WORD_SIZE  read values, same packing
//  rd_status  out  NUM_READ*FU_INDEX   read tags, same packing
//  iss_valid  in   1                   rename request this cycle
//  iss_reg    in   REG_INDEX           destination register to rename
//  iss_tag    in   FU_INDEX            producing FU tag
//  cdb_valid  in   1                   CDB broadcast valid
//  cdb_tag    in   FU_INDEX            completing FU tag
//  cdb_data   in   WORD_SIZE           result value
//  flush      in   1                   mispredict/exception: clear all pending tags
//  busy_count out  REG_INDEX+1         number of registers with status != READY
// BEHAVIOUR
//  Reset (reset_n=0, async): all values = 0, all statuses = READY, busy_count = 0.
//  Reads are combinational from current state (plus bypass, see CONFIGURATION).
//  CDB (cdb_valid, cdb_tag != READY): at posedge, every reg with status == cdb_tag gets
//   value <= cdb_data, status <= READY. Multiple matches all update. No match: no effect.
//   cdb_valid with cdb_tag == READY is ignored entirely.
//  Issue (iss_valid): at posedge, status[iss_reg] <= iss_tag; value unchanged. iss_tag == READY is legal
//   and marks the reg ready without changing its value.
//  Issue + CDB same reg same cycle: value written if old status == cdb_tag; status takes iss_tag (issue wins).
//  Flush: at posedge all statuses <= READY; values kept; concurrent issue ignored; concurrent CDB value
//   writes still applied to matching regs.
//  Issue write visible to reads one cycle later (no issue->read bypass).
//  busy_count: combinational popcount of status != READY over all REG_FILE_SIZE entries.
//  Reset asserted mid-operation overrides all inputs immediately; state held in reset until reset_n=1.
// CONFIGURATION
//  RS_CDB_BYPASS_EN defined: for each read port, if cdb_valid && cdb_tag != READY && current status
//   == cdb_tag, rd_value = cdb_data and rd_status = READY in the same cycle.
//  Undefined: reads return stored state only; CDB result visible the cycle after broadcast.
// STRUCTURE
//  parameters.v: WORD_SIZE, REG_INDEX, REG_FILE_SIZE, FU_INDEX, READY (shared with RS/FU blocks).
//  Sub-module reg_status_entry: one value + tag, async reset, issue/CDB/flush update logic, match flag;
//   generated REG_FILE_SIZE times. Top holds read muxes, bypass, popcount.
// TESTING
//  Reset: pulse reset_n low between edges -> all rd_status = 0, rd_value = 0, busy_count = 0 at once.
//  Issue r3 tag 2, next cycle read r3 -> status 2, busy_count 1; CDB tag 2 data 0xDEAD -> next cycle
//   r3 = 0xDEAD, READY, busy_count 0.
//  Issue r4 tag 5 and r7 tag 5 (two cycles), CDB tag 5 data 0x55 -> both r4 and r7 = 0x55, READY.
//  r1 status 3; same cycle issue r1 tag 4 + CDB tag 3 data 0x11 -> r1 value 0x11, status 4.
//  r2 tag 1, r5 tag 6, flush with issue r9 tag 2 -> all statuses READY, r9 not renamed, busy_count 0.
//  Bypass: r6 tag 3, read r6 during CDB tag 3 data 0x77 -> with RS_CDB_BYPASS_EN 0x77/READY same
//   cycle; without it old value/tag 3 that cycle, 0x77/READY next.

Source files
------------

// File: rtl/reg_status_table_pkg.sv
// rtl/reg_status_table_pkg.sv - shared sizing constants for the register/status table
package reg_status_table_pkg;

    localparam int RST_WORD_SIZE = 32;
    localparam int RST_REG_INDEX = 5;
    localparam int RST_FU_INDEX  = 3;
    localparam int RST_NUM_READ  = 3;
    localparam int RST_READY     = 0;

endpackage

// File: rtl/reg_status_table_entry.sv
// rtl/reg_status_table_entry.sv - one architectural register: value plus pending-producer tag
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   i_iss_we       rename this entry (already qualified by flush and index decode)
//   i_iss_tag      new producer tag
//   i_cdb_hit      CDB broadcast valid with a tag other than READY
//   i_cdb_tag      completing tag
//   i_cdb_data     completing value
//   i_flush        drop any pending producer
//   o_value        stored value
//   o_status       stored tag (READY when value is valid)
//   o_match        this entry is waiting on the tag being broadcast
//   o_busy         status != READY
module reg_status_table_entry
    import reg_status_table_pkg::*;
#(
    parameter int                  WORD_SIZE = RST_WORD_SIZE,
    parameter int                  FU_INDEX  = RST_FU_INDEX,
    parameter logic [FU_INDEX-1:0] READY     = FU_INDEX'(RST_READY)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_iss_we,
    input  logic [FU_INDEX-1:0]  i_iss_tag,
    input  logic                 i_cdb_hit,
    input  logic [FU_INDEX-1:0]  i_cdb_tag,
    input  logic [WORD_SIZE-1:0] i_cdb_data,
    input  logic                 i_flush,
    output logic [WORD_SIZE-1:0] o_value,
    output logic [FU_INDEX-1:0]  o_status,
    output logic                 o_match,
    output logic                 o_busy
);

    logic [WORD_SIZE-1:0] r_value;
    logic [FU_INDEX-1:0]  r_status;
    logic                 w_match;

    assign w_match = i_cdb_hit && (r_status == i_cdb_tag);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_value  <= '0;
            r_status <= READY;
        end else begin
            // The value capture uses the pre-edge tag, so a result still lands
            // even when the same register is renamed or flushed this cycle.
            if (w_match) begin
                r_value <= i_cdb_data;
            end
            // Priority: flush, then a new rename, then retirement by the CDB.
            if (i_flush) begin
                r_status <= READY;
            end else if (i_iss_we) begin
                r_status <= i_iss_tag;
            end else if (w_match) begin
                r_status <= READY;
            end
        end
    end

    assign o_value  = r_value;
    assign o_status = r_status;
    assign o_match  = w_match;
    assign o_busy   = (r_status != READY);

endmodule

// File: rtl/reg_status_table.sv
// rtl/reg_status_table.sv - Tomasulo register file with per-register producer tags
//
// Optional feature macro: RS_CDB_BYPASS_EN (forward a matching CDB result to
// the read ports in the broadcast cycle).
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   rd_num         NUM_READ packed read indices
//   rd_value       NUM_READ packed read values
//   rd_status      NUM_READ packed read tags
//   iss_valid      rename request; iss_reg / iss_tag give register and producer
//   cdb_valid      result broadcast; cdb_tag / cdb_data give producer and value
//   flush          return every register to READY
//   busy_count     number of registers waiting on a producer
module reg_status_table
    import reg_status_table_pkg::*;
#(
    parameter int                  WORD_SIZE = RST_WORD_SIZE,
    parameter int                  REG_INDEX = RST_REG_INDEX,
    parameter int                  FU_INDEX  = RST_FU_INDEX,
    parameter int                  NUM_READ  = RST_NUM_READ,
    parameter logic [FU_INDEX-1:0] READY     = FU_INDEX'(RST_READY)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_READ*REG_INDEX-1:0] rd_num,
    output logic [NUM_READ*WORD_SIZE-1:0] rd_value,
    output logic [NUM_READ*FU_INDEX-1:0]  rd_status,
    input  logic                          iss_valid,
    input  logic [REG_INDEX-1:0]          iss_reg,
    input  logic [FU_INDEX-1:0]           iss_tag,
    input  logic                          cdb_valid,
    input  logic [FU_INDEX-1:0]           cdb_tag,
    input  logic [WORD_SIZE-1:0]          cdb_data,
    input  logic                          flush,
    output logic [REG_INDEX:0]            busy_count
);

    localparam int REG_FILE_SIZE = 1 << REG_INDEX;

    logic                 w_cdb_hit;
    logic [WORD_SIZE-1:0] w_values [REG_FILE_SIZE];
    logic [FU_INDEX-1:0]  w_status [REG_FILE_SIZE];
    logic                 w_match  [REG_FILE_SIZE];
    logic                 w_busy   [REG_FILE_SIZE];
    logic [REG_INDEX:0]   w_busy_count;

    // A broadcast of the READY tag carries no producer and is dropped.
    assign w_cdb_hit = cdb_valid && (cdb_tag != READY);

    for (genvar g = 0; g < REG_FILE_SIZE; g++) begin : g_entry
        logic w_iss_we;
        assign w_iss_we = iss_valid && !flush && (iss_reg == REG_INDEX'(g));

        reg_status_table_entry #(
            .WORD_SIZE (WORD_SIZE),
            .FU_INDEX  (FU_INDEX),
            .READY     (READY)
        ) u_entry (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_iss_we   (w_iss_we),
            .i_iss_tag  (iss_tag),
            .i_cdb_hit  (w_cdb_hit),
            .i_cdb_tag  (cdb_tag),
            .i_cdb_data (cdb_data),
            .i_flush    (flush),
            .o_value    (w_values[g]),
            .o_status   (w_status[g]),
            .o_match    (w_match[g]),
            .o_busy     (w_busy[g])
        );
    end

    always_comb begin
        rd_value  = '0;
        rd_status = '0;
        for (int k = 0; k < NUM_READ; k++) begin
`ifdef RS_CDB_BYPASS_EN
            if (w_match[rd_num[k*REG_INDEX +: REG_INDEX]]) begin
                rd_value[k*WORD_SIZE +: WORD_SIZE] = cdb_data;
                rd_status[k*FU_INDEX +: FU_INDEX]  = READY;
            end else begin
                rd_value[k*WORD_SIZE +: WORD_SIZE] = w_values[rd_num[k*REG_INDEX +: REG_INDEX]];
                rd_status[k*FU_INDEX +: FU_INDEX]  = w_status[rd_num[k*REG_INDEX +: REG_INDEX]];
            end
`else
            rd_value[k*WORD_SIZE +: WORD_SIZE] = w_values[rd_num[k*REG_INDEX +: REG_INDEX]];
            rd_status[k*FU_INDEX +: FU_INDEX]  = w_status[rd_num[k*REG_INDEX +: REG_INDEX]];
`endif
        end
    end

    // Match flags only feed the bypass path; keep them referenced otherwise.
    logic w_unused_match;
    always_comb begin
        w_unused_match = 1'b0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            w_unused_match = w_unused_match | w_match[i];
        end
    end

    always_comb begin
        w_busy_count = '0;
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            w_busy_count = w_busy_count + (REG_INDEX+1)'(w_busy[i]);
        end
    end

    assign busy_count = w_busy_count;

endmodule

// File: tb/tb_reg_status_table.sv
// tb/tb_reg_status_table.sv - directed vector bench for reg_status_table
module tb_reg_status_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [14:0] rd_num;
    logic [95:0] rd_value;
    logic [8:0]  rd_status;
    logic        iss_valid;
    logic [4:0]  iss_reg;
    logic [2:0]  iss_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_status_table dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_num     (rd_num),
        .rd_value   (rd_value),
        .rd_status  (rd_status),
        .iss_valid  (iss_valid),
        .iss_reg    (iss_reg),
        .iss_tag    (iss_tag),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .flush      (flush),
        .busy_count (busy_count)
    );

    typedef struct {
        logic        iss_v;
        logic [4:0]  iss_r;
        logic [2:0]  iss_t;
        logic        cdb_v;
        logic [2:0]  cdb_t;
        logic [31:0] cdb_d;
        logic        fl;
        logic [4:0]  ra;
        logic [31:0] va;
        logic [2:0]  sa;
        logic [4:0]  rb;
        logic [31:0] vb;
        logic [2:0]  sb;
        logic [5:0]  busy;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic iv, input logic [4:0] ir, input logic [2:0] it,
                                input logic cv, input logic [2:0] ct, input logic [31:0] cd,
                                input logic fl, input logic [4:0] ra, input logic [31:0] va,
                                input logic [2:0] sa, input logic [4:0] rb, input logic [31:0] vb,
                                input logic [2:0] sb, input logic [5:0] busy);
        vec_t v;
        v.iss_v = iv; v.iss_r = ir; v.iss_t = it;
        v.cdb_v = cv; v.cdb_t = ct; v.cdb_d = cd; v.fl = fl;
        v.ra = ra; v.va = va; v.sa = sa;
        v.rb = rb; v.vb = vb; v.sb = sb; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        iss_valid = 1'b0; iss_reg = '0; iss_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        flush = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] a, input logic [4:0] b);
        rd_num[4:0]   = a;
        rd_num[9:5]   = 5'd0;
        rd_num[14:10] = b;
    endtask

    initial begin
        //                 iss  reg   tag   cdb  tag   data          fl   ra    va            sa    rb    vb            sb    busy
        vecs[0]  = mk(1'b1, 5'd3,  3'd2, 1'b0, 3'd0, 32'h0,     1'b0, 5'd3,  32'h0,     3'd2, 5'd0, 32'h0,  3'd0, 6'd1);
        vecs[1]  = mk(1'b0, 5'd0,  3'd0, 1'b1, 3'd2, 32'hDEAD,  1'b0, 5'd3,  32'hDEAD,  3'd0, 5'd0, 32'h0,  3'd0, 6'd0);
        vecs[2]  = mk(1'b1, 5'd4,  3'd5, 1'b0, 3'd0, 32'h0,     1'b0, 5'd4,  32'h0,     3'd5, 5'd0, 32'h0,  3'd0, 6'd1);
        vecs[3]  = mk(1'b1, 5'd7,  3'd5, 1'b0, 3'd0, 32'h0,     1'b0, 5'd7,  32'h0,     3'd5, 5'd4, 32'h0,  3'd5, 6'd2);
        vecs[4]  = mk(1'b0, 5'd0,  3'd0, 1'b1, 3'd5, 32'h55,    1'b0, 5'd4,  32'h55,    3'd0, 5'd7, 32'h55, 3'd0, 6'd0);
        vecs[5]  = mk(1'b1, 5'd1,  3'd3, 1'b0, 3'd0, 32'h0,     1'b0, 5'd1,  32'h0,     3'd3, 5'd0, 32'h0,  3'd0, 6'd1);
        vecs[6]  = mk(1'b1, 5'd1,  3'd4, 1'b1, 3'd3, 32'h11,    1'b0, 5'd1,  32'h11,    3'd4, 5'd0, 32'h0,  3'd0, 6'd1);
        vecs[7]  = mk(1'b0, 5'd0,  3'd0, 1'b1, 3'd0, 32'h99,    1'b0, 5'd1,  32'h11,    3'd4, 5'd0, 32'h0,  3'd0, 6'd1);
        vecs[8]  = mk(1'b1, 5'd2,  3'd1, 1'b0, 3'd0, 32'h0,     1'b0, 5'd2,  32'h0,     3'd1, 5'd1, 32'h11, 3'd4, 6'd2);
        vecs[9]  = mk(1'b1, 5'd5,  3'd6, 1'b0, 3'd0, 32'h0,     1'b0, 5'd5,  32'h0,     3'd6, 5'd2, 32'h0,  3'd1, 6'd3);
        vecs[10] = mk(1'b1, 5'd9,  3'd2, 1'b1, 3'd4, 32'h44,    1'b1, 5'd9,  32'h0,     3'd0, 5'd1, 32'h44, 3'd0, 6'd0);
        vecs[11] = mk(1'b1, 5'd31, 3'd7, 1'b0, 3'd0, 32'h0,     1'b0, 5'd31, 32'h0,     3'd7, 5'd5, 32'h0,  3'd0, 6'd1);
        vecs[12] = mk(1'b1, 5'd31, 3'd0, 1'b0, 3'd0, 32'h0,     1'b0, 5'd31, 32'h0,     3'd0, 5'd2, 32'h0,  3'd0, 6'd0);
        vecs[13] = mk(1'b0, 5'd0,  3'd0, 1'b1, 3'd7, 32'h77,    1'b0, 5'd31, 32'h0,     3'd0, 5'd1, 32'h44, 3'd0, 6'd0);

        reset_n = 1'b1;
        idle();
        set_reads(5'd0, 5'd0);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_busy",    32'(busy_count),       32'd0);
        chk("reset_status",  32'(rd_status),        32'd0);
        chk("reset_value0",  rd_value[31:0],        32'd0);
        chk("reset_value2",  rd_value[95:64],       32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            iss_valid = vecs[i].iss_v; iss_reg = vecs[i].iss_r; iss_tag = vecs[i].iss_t;
            cdb_valid = vecs[i].cdb_v; cdb_tag = vecs[i].cdb_t; cdb_data = vecs[i].cdb_d;
            flush = vecs[i].fl;
            @(posedge clk);
            #1;
            idle();
            set_reads(vecs[i].ra, vecs[i].rb);
            #1;
            chk($sformatf("v%0d_val_a", i),  rd_value[31:0],       vecs[i].va);
            chk($sformatf("v%0d_stat_a", i), 32'(rd_status[2:0]),  32'(vecs[i].sa));
            chk($sformatf("v%0d_val_b", i),  rd_value[95:64],      vecs[i].vb);
            chk($sformatf("v%0d_stat_b", i), 32'(rd_status[8:6]),  32'(vecs[i].sb));
            chk($sformatf("v%0d_busy", i),   32'(busy_count),      32'(vecs[i].busy));
        end

        // Mid-operation reset: state clears at once and holds through an edge.
        @(negedge clk);
        iss_valid = 1'b1; iss_reg = 5'd10; iss_tag = 3'd1;
        @(negedge clk);
        iss_reg = 5'd12; iss_tag = 3'd2;
        set_reads(5'd1, 5'd10);
        #1;
        chk("pre_reset_busy", 32'(busy_count), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("async_reset_busy",  32'(busy_count),      32'd0);
        chk("async_reset_val",   rd_value[31:0],       32'd0);
        chk("async_reset_stat",  32'(rd_status[8:6]),  32'd0);
        @(posedge clk);
        #1;
        chk("held_reset_busy",   32'(busy_count),      32'd0);
        @(negedge clk);
        idle();
        reset_n = 1'b1;

        // Issue is not forwarded to reads; CDB forwarding depends on the build.
        @(negedge clk);
        iss_valid = 1'b1; iss_reg = 5'd6; iss_tag = 3'd3;
        set_reads(5'd6, 5'd0);
        #1;
        chk("no_iss_bypass", 32'(rd_status[2:0]), 32'd0);
        @(negedge clk);
        idle();
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h77;
        #1;
`ifdef RS_CDB_BYPASS_EN
        chk("bypass_val",  rd_value[31:0],      32'h77);
        chk("bypass_stat", 32'(rd_status[2:0]), 32'd0);
`else
        chk("nobypass_val",  rd_value[31:0],      32'h0);
        chk("nobypass_stat", 32'(rd_status[2:0]), 32'd3);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
        chk("after_cdb_val",  rd_value[31:0],      32'h77);
        chk("after_cdb_stat", 32'(rd_status[2:0]), 32'd0);
        chk("after_cdb_busy", 32'(busy_count),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
